ezm_cpu_p: RTL and testbench
============================

# ezm_cpu_p

Parametrised accumulator CPU: the successor to the 8-bit ezm accumulator core. It takes one instruction per accepted handshake from the input pins, and executes it in a single cycle against an accumulator and a register bank of configurable width and depth. It adds SUB, LD, shifts, two's-complement negate, flags, HALT/resume, and a valid/ready instruction handshake. A TinyTapeout wrapper feeds it instructions and muxes its status outputs onto io_out.

## Interface
- DATA_W, 8: accumulator and bank word width (≥ 4).
- REG_AW, 3: bank address width; bank depth = 2**REG_AW.
- OPW, 5: operand field width (≥ REG_AW); instruction width IW = OPW+3.
- PC_W, 8: program counter width.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- instr_i  in  IW  instruction: opcode instr_i[IW-1:OPW], operand instr_i[OPW-1:0].
- instr_valid_i  in  1  instr_i holds a valid instruction.
- instr_ready_o  out  1  core accepts an instruction this cycle; equals !halted_o.
- resume_i  in  1  clears the halt state.
- acc_o  out  DATA_W  accumulator.
- pc_o  out  PC_W  program counter.
- carry_o  out  1  carry/borrow flag.
- zero_o  out  1  accumulator-zero flag.
- halted_o  out  1  core is halted.

## Operation
- Fire = instr_valid_i & instr_ready_o. No state changes without fire, except halt/resume.
- Operand r = operand[REG_AW-1:0]. Immediate = operand sign-extended or truncated to DATA_W.
- Opcode 000, MISC, selected by operand value:
  - 0 NOP.
  - 1 NOT: acc ← ~acc.
  - 2 NEG: acc ← -acc.
  - 3 SHL: acc ← acc<<1, carry ← old msb.
  - 4 SHR (logical): acc ← acc>>1, carry ← old lsb.
  - 5 HALT.
  - Any other value executes as NOP.
- 001 LDI: acc ← imm.
- 010 ST: bank[r] ← acc.
- 011 ADD: acc ← acc + bank[r], carry ← carry-out.
- 100 SUB: acc ← acc − bank[r], carry ← borrow (1 when bank[r] > acc, unsigned).
- 101 BGT: if bank[r] > acc (unsigned), pc ← pc − acc[PC_W-1:0] (acc zero-extended when PC_W > DATA_W). Otherwise the normal increment applies.
- 110 LD: acc ← bank[r].
- 111 CLC: carry ← 0.
- zero_o ← (new acc == 0) on every instruction that writes acc. It is unchanged otherwise.
- carry_o changes only on ADD/SUB/SHL/SHR/CLC.
- PC: on every fire, pc ← pc+1 unless BGT is taken. Arithmetic is modulo 2**PC_W and wraps.
- Halt state machine, states RUN and HALT:
  - RUN→HALT on a fired HALT instruction. The PC still increments for that instruction.
  - HALT→RUN when resume_i=1.
  - resume_i is ignored in RUN.
  - In HALT, instr_ready_o=0 and all state is frozen.

## Timing
- Single-cycle execute: results are visible on outputs the cycle after fire. No pipeline and no branch delay slot; the next fire executes at the updated pc.
- Bank reads are combinational. An ST followed by LD/ADD of the same r on the next fire sees the stored value.
- instr_ready_o falls in the cycle after HALT fires. It rises in the cycle after resume_i is sampled high.
- Reset (rst low, asynchronous, any time including mid-instruction or while halted):
  - acc=0, pc=0, bank all 0.
  - carry=0, zero=1, state RUN, instr_ready_o=1.
  - The instruction in flight is discarded.
- Deassertion of rst is synchronised externally. The first fire can occur on the first rising edge with rst high.

## Structure
- Package ezm_cpu_pkg holds:
  - opcode localparams OP_MISC..OP_CLC;
  - MISC sub-op constants;
  - the RUN/HALT state encoding.
- Sub-module ezm_cpu_alu (combinational):
  - inputs: acc, bank operand, opcode, sub-op;
  - outputs: result, carry, write-acc enable.
- The top holds the bank, pc, flags, halt FSM and handshake.

## Test plan
All scenarios use default parameters.
- Reset/load/store:
  - stimulus: reset, then LDI 0x0F, ST r2, LDI 0x1E (sign-extends), LD r2;
  - response: acc 0x0F, 0xFE, 0x0F; pc=4; zero=0.
- Arithmetic and flags:
  - stimulus: LDI 0x0F; ST r1; ADD r1; then SUB r1 twice;
  - response: acc goes 0x1E → 0x0F → 0x00 with zero=1 and carry=0; a further SUB r1 gives 0xF1 with carry=1.
- Branch:
  - stimulus: at pc=10 with acc=3 and bank[0]=5, BGT r0;
  - response: pc=7.
  - stimulus: the same with bank[0]=3;
  - response: pc=11.
  - stimulus: at pc=1 with acc=3;
  - response: taken branch wraps pc to 0xFE.
- Handshake:
  - stimulus: toggle instr_valid_i low for 3 cycles mid-program;
  - response: pc/acc unchanged during the gap; the instruction held under valid=0 is not executed.
- Halt/resume:
  - stimulus: HALT, then hold valid high with LDI 1 for 4 cycles, then pulse resume_i;
  - response: instr_ready_o=0 and acc unchanged while halted; ready returns the cycle after resume; LDI 1 executes.
- Async reset mid-run:
  - stimulus: assert rst between clock edges while halted with acc=0x55;
  - response: all outputs take reset values immediately without a clock edge.

Source files
------------

// File: rtl/ezm_cpu_pkg.sv
// Shared opcodes, MISC sub-op codes and halt-FSM encoding for the ezm_cpu_p core.
package ezm_cpu_pkg;

  localparam logic [2:0] OP_MISC = 3'b000;
  localparam logic [2:0] OP_LDI  = 3'b001;
  localparam logic [2:0] OP_ST   = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_BGT  = 3'b101;
  localparam logic [2:0] OP_LD   = 3'b110;
  localparam logic [2:0] OP_CLC  = 3'b111;

  // MISC sub-ops, matched against the whole operand field
  localparam int unsigned MISC_NOP  = 0;
  localparam int unsigned MISC_NOT  = 1;
  localparam int unsigned MISC_NEG  = 2;
  localparam int unsigned MISC_SHL  = 3;
  localparam int unsigned MISC_SHR  = 4;
  localparam int unsigned MISC_HALT = 5;

  typedef enum logic {
    StRun  = 1'b0,
    StHalt = 1'b1
  } state_e;

endpackage

// File: rtl/ezm_cpu_alu.sv
// Combinational datapath: computes the new accumulator and carry for one instruction.
module ezm_cpu_alu
  import ezm_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OPW    = 5
) (
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] opnd_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [2:0]        opcode_i,
  input  logic [OPW-1:0]    subop_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_o,
  output logic              carry_we_o,
  output logic              acc_we_o
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Extra top bit carries the carry-out / borrow.
  assign sum  = {1'b0, acc_i} + {1'b0, opnd_i};
  assign diff = {1'b0, acc_i} - {1'b0, opnd_i};

  // Decode opcode and sub-op into result, carry and write enables.
  always_comb begin
    result_o   = acc_i;
    carry_o    = 1'b0;
    carry_we_o = 1'b0;
    acc_we_o   = 1'b0;
    unique case (opcode_i)
      OP_MISC: begin
        case (subop_i)
          OPW'(MISC_NOT): begin
            result_o = ~acc_i;
            acc_we_o = 1'b1;
          end
          OPW'(MISC_NEG): begin
            result_o = '0 - acc_i;
            acc_we_o = 1'b1;
          end
          OPW'(MISC_SHL): begin
            result_o   = {acc_i[DATA_W-2:0], 1'b0};
            carry_o    = acc_i[DATA_W-1];
            carry_we_o = 1'b1;
            acc_we_o   = 1'b1;
          end
          OPW'(MISC_SHR): begin
            result_o   = {1'b0, acc_i[DATA_W-1:1]};
            carry_o    = acc_i[0];
            carry_we_o = 1'b1;
            acc_we_o   = 1'b1;
          end
          default: ;
        endcase
      end
      OP_LDI: begin
        result_o = imm_i;
        acc_we_o = 1'b1;
      end
      OP_ADD: begin
        result_o   = sum[DATA_W-1:0];
        carry_o    = sum[DATA_W];
        carry_we_o = 1'b1;
        acc_we_o   = 1'b1;
      end
      OP_SUB: begin
        result_o   = diff[DATA_W-1:0];
        carry_o    = diff[DATA_W];
        carry_we_o = 1'b1;
        acc_we_o   = 1'b1;
      end
      OP_LD: begin
        result_o = opnd_i;
        acc_we_o = 1'b1;
      end
      OP_CLC: begin
        carry_o    = 1'b0;
        carry_we_o = 1'b1;
      end
      default: ; // ST and BGT leave acc and carry alone
    endcase
  end

endmodule

// File: rtl/ezm_cpu_p.sv
// Accumulator CPU top: register bank, pc, flags, halt FSM and valid/ready handshake.
module ezm_cpu_p
  import ezm_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned REG_AW = 3,
  parameter int unsigned OPW    = 5,
  parameter int unsigned PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OPW+2:0]    instr_i,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  input  logic              resume_i,
  output logic [DATA_W-1:0] acc_o,
  output logic [PC_W-1:0]   pc_o,
  output logic              carry_o,
  output logic              zero_o,
  output logic              halted_o
);

  localparam int unsigned Depth = 2 ** REG_AW;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic                carry_q, carry_d;
  logic                zero_q, zero_d;
  logic [DATA_W-1:0]   bank_q [Depth];

  logic [2:0]          opcode;
  logic [OPW-1:0]      operand;
  logic [REG_AW-1:0]   reg_idx;
  logic [DATA_W-1:0]   bank_rd;
  logic [DATA_W-1:0]   imm;
  logic [PC_W-1:0]     acc_pc;
  logic [DATA_W-1:0]   alu_result;
  logic                alu_carry, alu_carry_we, alu_acc_we;
  logic                fire, is_halt, bgt_taken;

  assign opcode  = instr_i[OPW+2:OPW];
  assign operand = instr_i[OPW-1:0];
  assign reg_idx = operand[REG_AW-1:0];
  assign bank_rd = bank_q[reg_idx];

  // Immediate is sign-extended when narrower than the word, truncated otherwise;
  // acc is zero-extended or truncated to pc width for the branch offset.
  always_comb begin
    imm    = '0;
    acc_pc = '0;
    for (int i = 0; i < DATA_W; i++) begin
      imm[i] = (i < OPW) ? operand[i] : operand[OPW-1];
    end
    for (int i = 0; i < PC_W; i++) begin
      acc_pc[i] = (i < DATA_W) ? acc_q[i] : 1'b0;
    end
  end

  ezm_cpu_alu #(
    .DATA_W (DATA_W),
    .OPW    (OPW)
  ) u_alu (
    .acc_i      (acc_q),
    .opnd_i     (bank_rd),
    .imm_i      (imm),
    .opcode_i   (opcode),
    .subop_i    (operand),
    .result_o   (alu_result),
    .carry_o    (alu_carry),
    .carry_we_o (alu_carry_we),
    .acc_we_o   (alu_acc_we)
  );

  assign instr_ready_o = (state_q == StRun);
  assign fire          = instr_valid_i & instr_ready_o;
  assign is_halt       = (opcode == OP_MISC) && (operand == OPW'(MISC_HALT));
  assign bgt_taken     = (opcode == OP_BGT) && (bank_rd > acc_q);

  // Next-state for architectural registers and the halt FSM.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    pc_d    = pc_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    unique case (state_q)
      StRun: begin
        if (fire) begin
          pc_d = bgt_taken ? (pc_q - acc_pc) : (pc_q + PC_W'(1));
          if (alu_acc_we) begin
            acc_d  = alu_result;
            zero_d = (alu_result == '0);
          end
          if (alu_carry_we) begin
            carry_d = alu_carry;
          end
          if (is_halt) begin
            state_d = StHalt;
          end
        end
      end
      StHalt: begin
        if (resume_i) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Architectural state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      acc_q   <= '0;
      pc_q    <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      pc_q    <= pc_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  // Register bank, written by a fired ST.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) begin
        bank_q[i] <= '0;
      end
    end else if (fire && (opcode == OP_ST)) begin
      bank_q[reg_idx] <= acc_q;
    end
  end

  assign acc_o    = acc_q;
  assign pc_o     = pc_q;
  assign carry_o  = carry_q;
  assign zero_o   = zero_q;
  assign halted_o = (state_q == StHalt);

endmodule

// File: tb/tb_ezm_cpu_p.sv
// Self-checking bench for ezm_cpu_p with default parameters.
module tb_ezm_cpu_p;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] instr_i = '0;
  logic       instr_valid_i = 1'b0;
  logic       resume_i = 1'b0;
  logic       instr_ready_o;
  logic [7:0] acc_o;
  logic [7:0] pc_o;
  logic       carry_o, zero_o, halted_o;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  ezm_cpu_p dut (
    .clk           (clk),
    .rst           (rst),
    .instr_i       (instr_i),
    .instr_valid_i (instr_valid_i),
    .instr_ready_o (instr_ready_o),
    .resume_i      (resume_i),
    .acc_o         (acc_o),
    .pc_o          (pc_o),
    .carry_o       (carry_o),
    .zero_o        (zero_o),
    .halted_o      (halted_o)
  );

  always #5 clk = ~clk;

  // Reference model in plain integer arithmetic.
  int m_acc, m_pc, m_bank [8];
  bit m_c, m_z, m_halt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_acc  <= 0;
      m_pc   <= 0;
      m_c    <= 1'b0;
      m_z    <= 1'b1;
      m_halt <= 1'b0;
      for (int i = 0; i < 8; i++) m_bank[i] <= 0;
    end else if (m_halt) begin
      if (resume_i) m_halt <= 1'b0;
    end else if (instr_valid_i) begin : exec
      int op, x, r, a, b, na, npc;
      bit nc, wr;
      op  = int'(instr_i[7:5]);
      x   = int'(instr_i[4:0]);
      r   = x % 8;
      a   = m_acc;
      b   = m_bank[r];
      na  = a;
      nc  = m_c;
      wr  = 1'b0;
      npc = (m_pc + 1) % 256;
      case (op)
        0: case (x)
          1: begin na = 255 - a; wr = 1; end
          2: begin na = (256 - a) % 256; wr = 1; end
          3: begin nc = (a >= 128); na = (a * 2) % 256; wr = 1; end
          4: begin nc = (a % 2) == 1; na = a / 2; wr = 1; end
          5: m_halt <= 1'b1;
          default: ;
        endcase
        1: begin na = (x >= 16) ? x + 224 : x; wr = 1; end
        2: m_bank[r] <= a;
        3: begin nc = (a + b) > 255; na = (a + b) % 256; wr = 1; end
        4: begin nc = b > a; na = (a - b + 256) % 256; wr = 1; end
        5: if (b > a) npc = (m_pc - (a % 256) + 256) % 256;
        6: begin na = b; wr = 1; end
        default: nc = 1'b0;
      endcase
      m_acc <= na;
      m_c   <= nc;
      m_pc  <= npc;
      if (wr) m_z <= (na == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model acc", 32'(acc_o), 32'(m_acc));
      chk("model pc", 32'(pc_o), 32'(m_pc));
      chk("model carry", 32'(carry_o), 32'(m_c));
      chk("model zero", 32'(zero_o), 32'(m_z));
      chk("model halted", 32'(halted_o), 32'(m_halt));
      chk("model ready", 32'(instr_ready_o), 32'(!m_halt));
    end
  end

  function automatic logic [7:0] ins(input logic [2:0] op, input logic [4:0] x);
    return {op, x};
  endfunction

  task automatic step(input logic v, input logic [7:0] ins_v);
    instr_valid_i = v;
    instr_i       = ins_v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    chk("reset acc", 32'(acc_o), 32'h0);
    chk("reset zero", 32'(zero_o), 32'h1);
    chk("reset ready", 32'(instr_ready_o), 32'h1);
    rst = 1'b1;

    // Load/store with sign-extended immediate.
    step(1, ins(3'd1, 5'h0F));
    chk("ldi 0f", 32'(acc_o), 32'h0F);
    step(1, ins(3'd2, 5'd2));
    step(1, ins(3'd1, 5'h1E));
    chk("ldi 1e sext", 32'(acc_o), 32'hFE);
    step(1, ins(3'd6, 5'd2));
    chk("ld r2", 32'(acc_o), 32'h0F);
    chk("pc after 4", 32'(pc_o), 32'd4);
    chk("zero after ld", 32'(zero_o), 32'h0);

    // Arithmetic and flags.
    step(1, ins(3'd1, 5'h0F));
    step(1, ins(3'd2, 5'd1));
    step(1, ins(3'd3, 5'd1));
    chk("add", 32'(acc_o), 32'h1E);
    step(1, ins(3'd4, 5'd1));
    chk("sub1", 32'(acc_o), 32'h0F);
    step(1, ins(3'd4, 5'd1));
    chk("sub2 acc", 32'(acc_o), 32'h00);
    chk("sub2 zero", 32'(zero_o), 32'h1);
    chk("sub2 carry", 32'(carry_o), 32'h0);
    step(1, ins(3'd4, 5'd1));
    chk("sub3 acc", 32'(acc_o), 32'hF1);
    chk("sub3 borrow", 32'(carry_o), 32'h1);
    chk("pc 10", 32'(pc_o), 32'd10);

    // Branches: bank0=5, acc=3.
    step(1, ins(3'd1, 5'd5));
    step(1, ins(3'd2, 5'd0));
    step(1, ins(3'd1, 5'd3));
    step(1, ins(3'd5, 5'd0));
    chk("bgt 13->10", 32'(pc_o), 32'd10);
    step(1, ins(3'd5, 5'd0));
    chk("bgt 10->7", 32'(pc_o), 32'd7);
    step(1, ins(3'd1, 5'd3));
    step(1, ins(3'd2, 5'd0));
    step(1, ins(3'd1, 5'd3));
    step(1, ins(3'd5, 5'd0));
    chk("bgt not taken", 32'(pc_o), 32'd11);
    step(1, ins(3'd1, 5'h1E));
    step(1, ins(3'd2, 5'd1));
    step(1, ins(3'd1, 5'd14));
    step(1, ins(3'd5, 5'd1));
    chk("bgt to 0", 32'(pc_o), 32'd0);
    step(1, ins(3'd1, 5'd3));
    step(1, ins(3'd5, 5'd1));
    chk("bgt wrap", 32'(pc_o), 32'hFE);

    // Handshake gap: held instruction must not execute.
    repeat (3) step(0, ins(3'd1, 5'd7));
    chk("gap acc", 32'(acc_o), 32'h03);
    chk("gap pc", 32'(pc_o), 32'hFE);

    // MISC ops.
    step(1, ins(3'd1, 5'h0A));
    chk("pc wrap ff", 32'(pc_o), 32'hFF);
    step(1, ins(3'd0, 5'd1));
    chk("not", 32'(acc_o), 32'hF5);
    step(1, ins(3'd0, 5'd2));
    chk("neg", 32'(acc_o), 32'h0B);
    step(1, ins(3'd0, 5'd4));
    chk("shr acc", 32'(acc_o), 32'h05);
    chk("shr carry", 32'(carry_o), 32'h1);
    step(1, ins(3'd7, 5'd0));
    chk("clc", 32'(carry_o), 32'h0);
    step(1, ins(3'd0, 5'd0));
    step(1, ins(3'd0, 5'd9));
    step(1, ins(3'd2, 5'd3));
    repeat (4) step(1, ins(3'd0, 5'd3));
    step(1, ins(3'd3, 5'd3));
    chk("build 55", 32'(acc_o), 32'h55);
    step(1, ins(3'd2, 5'd4));

    // Halt / resume.
    step(1, ins(3'd0, 5'd5));
    chk("halt pc", 32'(pc_o), 32'd13);
    chk("halt ready", 32'(instr_ready_o), 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1, ins(3'd1, 5'd1));
      chk("halted acc", 32'(acc_o), 32'h55);
    end
    resume_i = 1'b1;
    step(1, ins(3'd1, 5'd1));
    resume_i = 1'b0;
    chk("resume ready", 32'(instr_ready_o), 32'h1);
    chk("resume acc", 32'(acc_o), 32'h55);
    step(1, ins(3'd1, 5'd1));
    chk("post-resume ldi", 32'(acc_o), 32'h01);
    step(1, ins(3'd6, 5'd4));
    step(1, ins(3'd0, 5'd5));
    chk("rehalt", 32'(halted_o), 32'h1);

    // Async reset between edges while halted.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst acc", 32'(acc_o), 32'h0);
    chk("arst pc", 32'(pc_o), 32'h0);
    chk("arst zero", 32'(zero_o), 32'h1);
    chk("arst halted", 32'(halted_o), 32'h0);
    chk("arst ready", 32'(instr_ready_o), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    step(1, ins(3'd6, 5'd4));
    chk("bank cleared", 32'(acc_o), 32'h0);
    chk("pc after reset", 32'(pc_o), 32'd1);
    step(0, 8'h00);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
